alu_exec_unit: RTL and testbench

Execute-stage ALU consuming the registered `alu_op` produced by the ALU decoder one cycle earlier, together with the two operands from register read. Single-cycle arithmetic and logic ops; shifts run iteratively over several cycles to keep the barrel shifter small. Ready/valid handshakes on both sides. Results and comparison flags go to the branch/writeback logic downstream.

---
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU.
//   Single-cycle add/sub/compare/logic ops, iterative shifts (SHIFT_STEP bits
//   per cycle), ready/valid on both sides, branch flags captured at accept.
// Ports:
//   clock, reset_n         - rising-edge clock, async active-low reset
//   in_valid/in_ready      - upstream handshake
//   alu_op                 - {inst[30], funct3}
//   op_a, op_b             - operands (op_b[4:0] = shift amount for shifts)
//   rd_in / rd_out         - destination tag, carried through
//   out_valid/out_ready    - downstream handshake
//   result                 - ALU result
//   flag_eq/flag_lt/flag_ltu - a==b, signed a<b, unsigned a<b
module alu_exec_unit #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  alu_op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  rd_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        flag_eq,
   output logic        flag_lt,
   output logic        flag_ltu,
   output logic [4:0]  rd_out
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

   state_t      state, next_state, accept_state;
   logic [31:0] val_q;      // result in DONE, shift working value in SHIFT
   logic [4:0]  rem_q;
   logic        left_q, arith_q;
   logic        eq_q, lt_q, ltu_q;
   logic [4:0]  rd_q;

   logic [31:0] alu_res, shifted;
   logic        is_shift, accept, last_step;
   logic        cmp_eq, cmp_lt, cmp_ltu;
   logic [4:0]  step_amt;

   assign cmp_eq   = (op_a == op_b);
   assign cmp_lt   = ($signed(op_a) < $signed(op_b));
   assign cmp_ltu  = (op_a < op_b);
   assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

   // Shift ops load op_a unshifted; the SHIFT state does the work, so an
   // amount of 0 simply delivers op_a.
   always_comb begin
      alu_res = op_a + op_b;
      case (alu_op)
         OP_SUB:                 alu_res = op_a - op_b;
         OP_SLT:                 alu_res = {31'd0, cmp_lt};
         OP_SLTU:                alu_res = {31'd0, cmp_ltu};
         OP_XOR:                 alu_res = op_a ^ op_b;
         OP_OR:                  alu_res = op_a | op_b;
         OP_AND:                 alu_res = op_a & op_b;
         OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
         default:                alu_res = op_a + op_b;
      endcase
   end

   // One shift step: full SHIFT_STEP, or the leftover remainder on the tail.
   // Arithmetic right shift of the working value keeps the original sign bit.
   assign last_step = (rem_q <= STEP_W);
   assign step_amt  = last_step ? rem_q : STEP_W;

   always_comb begin
      if (left_q)       shifted = val_q << step_amt;
      else if (arith_q) shifted = 32'($signed(val_q) >>> step_amt);
      else              shifted = val_q >> step_amt;
   end

   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;   // back-to-back issue when draining
         default: in_ready = 1'b0;
      endcase
   end

   assign accept       = in_valid && in_ready;
   assign accept_state = (is_shift && (op_b[4:0] != 5'd0)) ? SHIFT : DONE;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = accept_state;
         SHIFT:   if (last_step) next_state = DONE;
         DONE:    if (out_ready) next_state = accept ? accept_state : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         val_q   <= '0;
         rem_q   <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         ltu_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            val_q   <= alu_res;
            rem_q   <= op_b[4:0];
            left_q  <= (alu_op == OP_SLL);
            arith_q <= (alu_op == OP_SRA);
            eq_q    <= cmp_eq;
            lt_q    <= cmp_lt;
            ltu_q   <= cmp_ltu;
            rd_q    <= rd_in;
         end else if (state == SHIFT) begin
            val_q <= shifted;
            rem_q <= rem_q - step_amt;
         end
      end
   end

   assign out_valid = (state == DONE);
   assign result    = val_q;
   assign flag_eq   = eq_q;
   assign flag_lt   = lt_q;
   assign flag_ltu  = ltu_q;
   assign rd_out    = rd_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one instance with SHIFT_STEP=1 and one
// with SHIFT_STEP=8 sharing operand inputs. Inputs change and outputs are
// sampled on the falling edge.
module tb_alu_exec_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid, in_valid8;
   logic        in_ready, in_ready8;
   logic [3:0]  alu_op;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        out_valid, out_valid8;
   logic        out_ready;
   logic [31:0] result, result8;
   logic        flag_eq, flag_lt, flag_ltu;
   logic        flag_eq8, flag_lt8, flag_ltu8;
   logic [4:0]  rd_out, rd_out8;

   int checks = 0;
   int errors = 0;
   int cnt;

   always #5 clock = ~clock;

   alu_exec_unit #(.SHIFT_STEP(1)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_eq(flag_eq), .flag_lt(flag_lt), .flag_ltu(flag_ltu), .rd_out(rd_out)
   );

   alu_exec_unit #(.SHIFT_STEP(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
      .flag_eq(flag_eq8), .flag_lt(flag_lt8), .flag_ltu(flag_ltu8), .rd_out(rd_out8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      alu_op = op; op_a = a; op_b = b; rd_in = rd;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
      drive(4'b0000, 32'd0, 32'd0, 5'd0);
      step(); step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, flag_eq, flag_lt, flag_ltu}, 32'd0);
      chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
      reset_n = 1'b1;
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // back-to-back ADD then SUB
      in_valid = 1'b1;
      drive(4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd3);
      step();
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_result", result, 32'h0);
      chk("add_ltu", {31'd0, flag_ltu}, 32'd0);
      chk("add_lt", {31'd0, flag_lt}, 32'd1);
      chk("add_rd", {27'd0, rd_out}, 32'd3);
      drive(4'b1000, 32'd5, 32'd7, 5'd4);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("sub_valid", {31'd0, out_valid}, 32'd1);
      chk("sub_result", result, 32'hFFFF_FFFE);
      chk("sub_lt", {31'd0, flag_lt}, 32'd1);
      chk("sub_rd", {27'd0, rd_out}, 32'd4);

      // SLT / SLTU on 0x80000000 vs 1
      drive(4'b0010, 32'h8000_0000, 32'd1, 5'd5);
      step();
      chk("slt_result", result, 32'd1);
      chk("slt_eq", {31'd0, flag_eq}, 32'd0);
      chk("slt_flags", {30'd0, flag_lt, flag_ltu}, 32'b10);
      drive(4'b0011, 32'h8000_0000, 32'd1, 5'd6);
      step();
      chk("sltu_result", result, 32'd0);

      // logic ops, unlisted code as ADD, equality flag
      drive(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
      step();
      chk("xor_result", result, 32'h0FF0_0FF0);
      drive(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
      step();
      chk("or_result", result, 32'hFFF0_FFF0);
      drive(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
      step();
      chk("and_result", result, 32'hF000_F000);
      drive(4'b1100, 32'd10, 32'd20, 5'd8);
      step();
      chk("op1100_add", result, 32'd30);
      drive(4'b0000, 32'd7, 32'd7, 5'd8);
      step();
      chk("eq_result", result, 32'd14);
      chk("eq_flag", {31'd0, flag_eq}, 32'd1);
      in_valid = 1'b0;
      step();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // SRA 0x80000000 by 4, SHIFT_STEP=1
      in_valid = 1'b1;
      drive(4'b1101, 32'h8000_0000, 32'd4, 5'd9);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("sra_busy_valid", {31'd0, out_valid}, 32'd0);
         chk("sra_busy_ready", {31'd0, in_ready}, 32'd0);
         if (i < 3) step();
      end
      step();
      chk("sra_valid", {31'd0, out_valid}, 32'd1);
      chk("sra_result", result, 32'hF800_0000);
      step();

      // SLL 1 by 31
      in_valid = 1'b1;
      drive(4'b0001, 32'd1, 32'd31, 5'd10);
      step();
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 40) begin step(); cnt++; end
      chk("sll_latency", cnt, 32'd31);
      chk("sll_result", result, 32'h8000_0000);
      step();

      // shift by 0 (op_b = 32, low bits zero)
      in_valid = 1'b1;
      drive(4'b0101, 32'h1234_5678, 32'd32, 5'd11);
      step();
      in_valid = 1'b0;
      chk("sh0_valid", {31'd0, out_valid}, 32'd1);
      chk("sh0_result", result, 32'h1234_5678);
      step();

      // SRL 0xFFFFFFFF by 31 with SHIFT_STEP=8
      in_valid8 = 1'b1;
      drive(4'b0101, 32'hFFFF_FFFF, 32'd31, 5'd12);
      step();
      in_valid8 = 1'b0;
      cnt = 0;
      while (!out_valid8 && cnt < 40) begin step(); cnt++; end
      chk("srl8_latency", cnt, 32'd4);
      chk("srl8_result", result8, 32'h1);
      step();

      // backpressure: hold in DONE, then accept on the draining edge
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(4'b0000, 32'd100, 32'd23, 5'd13);
      step();
      drive(4'b1000, 32'd50, 32'd8, 5'd14);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", result, 32'd123);
         chk("bp_flags", {29'd0, flag_eq, flag_lt, flag_ltu}, 32'd0);
         chk("bp_rd", {27'd0, rd_out}, 32'd13);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_next_result", result, 32'd42);
      chk("bp_next_rd", {27'd0, rd_out}, 32'd14);
      chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
      step();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // reset in the middle of a shift
      in_valid = 1'b1;
      drive(4'b0001, 32'd1, 32'd31, 5'd15);
      step();
      in_valid = 1'b0;
      step(); step();
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_no_result", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
